// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment display blocks
package seg7_pkg;

   localparam int NUM_DIGITS = 4;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low gfedcba patterns, indexed by nibble value (entry 15 listed first).
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-low segment pattern
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = HEX_SEG[nib];
   end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed hex display with per-scan snapshot
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        hold,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int DIV_W = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      shown_q, shown_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             tick;
   logic [3:0]       nib;
   logic [6:0]       dec_seg;
   logic             upper_zero;
   logic             blanked;

   seg7_decode u_decode (
      .nib (nib),
      .seg (dec_seg)
   );

   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      // The whole display value only changes at the end of the last digit slot.
      shown_d   = (tick && (idx_q == IDX_LAST) && !hold) ? value : shown_q;

      nib = shown_q[{idx_q, 2'b00} +: 4];

      upper_zero = 1'b0;
      case (idx_q)
         2'd1:    upper_zero = (shown_q[15:4]  == 12'h000);
         2'd2:    upper_zero = (shown_q[15:8]  == 8'h00);
         2'd3:    upper_zero = (shown_q[15:12] == 4'h0);
         default: upper_zero = 1'b0;
      endcase
      blanked = blank_lz && upper_zero;

      an_d  = blanked ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d = blanked ? SEG_BLANK : dec_seg;
      dp_d  = !((idx_q == 2'd0) && hold);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         idx_q     <= 2'd0;
         shown_q   <= 16'h0000;
         an_q      <= 4'b1111;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
      end else begin
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         shown_q   <= shown_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized self-checking bench for seg7_scan
module tb_seg7_scan;

   localparam int R = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = 16'h0000;
   logic        hold = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks = 0;
   int failures = 0;

   logic [6:0] hex_tbl [16];
   logic [15:0] m_shown;
   int          k;

   seg7_scan #(.REFRESH_DIV(R)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .value    (value),
      .hold     (hold),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, k);
      end
   endtask

   // One clock edge: predict outputs from edge number since release and the model's sampled value.
   task automatic cycle();
      int          slot;
      logic [15:0] upper;
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp;
      logic        h, b;
      logic [15:0] v;
      @(posedge clk);
      h = hold; b = blank_lz; v = value;
      k++;
      slot  = ((k - 1) / R) % 4;
      upper = m_shown >> (4 * slot);
      if (b && slot != 0 && upper == 16'h0) begin
         e_an  = 4'b1111;
         e_seg = 7'b1111111;
      end else begin
         e_an  = ~(4'b0001 << slot);
         e_seg = hex_tbl[upper[3:0]];
      end
      e_dp = !(slot == 0 && h);
      if ((k % (4 * R)) == 0 && !h) m_shown = v;
      #1;
      check_eq("an", {12'h0, an}, {12'h0, e_an});
      check_eq("seg", {9'h0, seg}, {9'h0, e_seg});
      check_eq("dp", {15'h0, dp}, {15'h0, e_dp});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      m_shown = 16'h0;
      k = 0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_an", {12'h0, an}, 16'h000F);
      check_eq("rst_seg", {9'h0, seg}, 16'h007F);
      check_eq("rst_dp", {15'h0, dp}, 16'h0001);

      rst_n = 1'b1;
      value = 16'h1234;
      cycle();
      check_eq("first_an", {12'h0, an}, 16'h000E);
      check_eq("first_seg", {9'h0, seg}, {9'h0, 7'b1000000});
      run(4 * R * 2);

      hold = 1'b1;
      value = 16'hABCD;
      run(4 * R * 2);
      hold = 1'b0;
      run(4 * R * 2);

      blank_lz = 1'b1;
      value = 16'h0007;
      run(4 * R * 2);
      value = 16'h0100;
      run(4 * R * 2);

      // Asynchronous reset landing mid-slot while digit 2 is being driven.
      value = 16'h5678;
      blank_lz = 1'b0;
      while (!(((k / R) % 4) == 2 && (k % R) == 1)) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_an", {12'h0, an}, 16'h000F);
      check_eq("arst_seg", {9'h0, seg}, 16'h007F);
      check_eq("arst_dp", {15'h0, dp}, 16'h0001);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_shown = 16'h0;
      k = 0;
      cycle();
      check_eq("arst_rel_an", {12'h0, an}, 16'h000E);
      check_eq("arst_rel_seg", {9'h0, seg}, {9'h0, 7'b1000000});
      run(4 * R * 2 - 1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) value = 16'($urandom);
         if ($urandom_range(0, 15) == 0) value = 16'($urandom_range(0, 300));
         if ($urandom_range(0, 20) == 0) hold = ~hold;
         if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
         cycle();
      end

      hold = 1'b0;
      blank_lz = 1'b1;
      value = 16'hFFD0;
      for (int i = 0; i < 160; i++) begin
         cycle();
         value = value + 16'd1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Display stage that consumes the 16-bit free-running count and shows it as four hex digits on a common-anode, time-multiplexed 7-segment display. It sits directly downstream of the counter, clocked by the same `clk`. A refresh prescaler walks one digit at a time. The displayed value is snapshotted once per full scan, so all four digits of a scan come from the same count (no tearing). Display freeze and leading-zero blanking are provided for lab use.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥2. Prescaler width is clog2(REFRESH_DIV).
- `clk`  in  1  system clock; all state on posedge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `value`  in  16  count from upstream counter; sampled only at scan boundary.
- `hold`  in  1  1 = suppress snapshot update; display frozen.
- `blank_lz`  in  1  1 = blank leading zero digits (digit 0 never blanked).
- `an`  out  4  digit enables, active-low; an[0] = least-significant nibble.
- `seg`  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- `dp`  out  1  decimal point, active-low.

## Operation
- State: `div_cnt`, `idx[1:0]`, `shown[15:0]`, plus registered `an`, `seg`, `dp`.
- Reset values: div_cnt=0, idx=0, shown=16'h0000, an=4'b1111, seg=7'b1111111, dp=1.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1. tick=1 when div_cnt==REFRESH_DIV-1; div_cnt then wraps to 0.
- On tick: idx <= idx+1, wrapping 3→0.
- Snapshot: on tick with idx==3 and hold==0, shown <= value. With hold==1, shown is unchanged.
- Nibble select: nib = shown[4*idx+3 : 4*idx].
- Blanking: with blank_lz=1, digit k (k=1..3) is blanked when shown[15:4k]==0. When blanked: an bit k stays 1 and seg=7'b1111111.
- Decode (gfedcba, active-low):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- Every cycle: an <= ~(4'b0001<<idx) (or 4'b1111 if the digit is blanked); seg <= decode(nib) (or blank).
- dp <= 0 only when idx==0 and hold==1 (freeze indicator); otherwise 1.
- Simultaneous events:
  - hold changing on the boundary tick: the value of hold at that edge decides the snapshot.
  - value changing mid-scan: no visible effect until the next boundary.
- Reset mid-operation: all registers return to reset values immediately, without a clock edge. Scanning restarts at digit 0 after rst_n deasserts.

## Timing
- Outputs are registered and lag idx by exactly 1 cycle.
- Each digit is driven for exactly REFRESH_DIV cycles. A full scan is 4·REFRESH_DIV cycles.
- First edge after reset release: an=4'b1110, seg=7'b1000000 (shown=0).
- First snapshot occurs at the edge ending cycle 4·REFRESH_DIV-1 after release. The new value appears on an[0] one cycle later.
- value→display latency: minimum 1 cycle after a boundary, maximum 4·REFRESH_DIV+1 cycles.
- The upstream count wrapping (16'hFFFF→16'h0000) needs no special handling; shown always holds one coherent sample.
- No combinational path from inputs to outputs.

## Structure
- Shared package `seg7_pkg`:
  - `NUM_DIGITS`=4
  - `SEG_BLANK`=7'b1111111
  - the 16-entry hex segment constant table
- Sub-module `seg7_decode`: combinational 4-bit nibble → 7-bit active-low pattern, reusable by other display blocks.
- Top holds the prescaler, digit index, snapshot register, blanking logic and output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold rst_n low for 3 edges → an=1111, seg=1111111, dp=1. Release → next edge an=1110, seg=1000000.
- value=16'h1234 held steady through one full scan → following scan shows:
  - digit0: an=1110, seg=0011001 ('4')
  - digit1: an=1101, seg=0110000 ('3')
  - digit2: an=1011, seg=0100100 ('2')
  - digit3: an=0111, seg=1111001 ('1')
  - each digit lasts exactly 4 cycles.
- hold=1 after 16'h1234 is shown, then value=16'hABCD → display stays 1234 and dp=0 on digit0 slots. Drop hold → next boundary shows D,C,B,A (0100001, 1000110, 0000011, 0001000).
- blank_lz=1, value=16'h0007 → digit0 seg=1111000 with an=1110; digit1..3 slots an=1111, seg=1111111. Repeat with value=16'h0100: digit1 and digit0 show '0', digit2 shows '1', digit3 blank.
- Assert rst_n asynchronously mid-slot at idx=2, between clock edges → an=1111, seg=1111111 immediately; shown reads 0 after release.
- Drive value from a live incrementing counter across 16'hFFFF→16'h0000 → every scan's four digits match a single sampled value taken at that scan's boundary.
